mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipelined MIPS core, directly downstream of the EX-stage ALU. It consumes the ALU result, which is either the writeback value or the effective address, plus the register-write controls. It performs loads and stores over a req/ack data-memory port, stalling EX while an access is outstanding. It then presents registered writeback signals to the WB stage.

## Interface
Parameters:
- MAX_WAIT, 15: cycles in ACCESS without dm_ack before the access is aborted (1..255).

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX presents an instruction this cycle
- ex_ready  out  1  stage accepts; transfer occurs when ex_valid && ex_ready at a rising edge
- ex_mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9..15 treated as NONE
- ex_reg_we  in  1  register write enable from EX (already cleared by EX on overflow)
- ex_reg_waddr  in  5  destination register
- ex_alu_res  in  32  ALU result / effective byte address
- ex_store_data  in  32  rt value for stores
- dm_req  out  1  memory request, held until dm_ack
- dm_we  out  1  1 = store
- dm_addr  out  32  word address ({ex_alu_res[31:2], 2'b00})
- dm_be  out  4  byte enables, little-endian lanes (be[0] = bits 7:0)
- dm_wdata  out  32  store data replicated into lanes
- dm_ack  in  1  access complete; dm_rdata valid in the same cycle
- dm_rdata  in  32  read word
- wb_valid  out  1  one-cycle writeback strobe
- wb_reg_we  out  1  write enable to the register file
- wb_reg_waddr  out  5  destination
- wb_reg_wdata  out  32  writeback data
- misalign_err  out  1  one-cycle pulse for a misaligned access
- timeout_err  out  1  one-cycle pulse for an aborted access

## Operation
- FSM states: IDLE, ACCESS. ex_ready = (state == IDLE).
- Accept in IDLE:
  - NONE op: registers wb_* directly; wb_reg_wdata = ex_alu_res; state stays IDLE.
  - Memory op: alignment is checked first. Halfword needs addr[0]=0; word needs addr[1:0]=0.
  - Misaligned: no memory request is issued. wb_valid=1, wb_reg_we=0, misalign_err=1, state stays IDLE.
  - Aligned: address, op, byte lane, waddr and we are latched; go to ACCESS.
- Stores: SB drives be = 1<<addr[1:0] and wdata = {4{data[7:0]}}. SH drives be = 4'b0011 or 4'b1100 and wdata = {2{data[15:0]}}. SW drives be = 4'b1111. A store writes no register: wb_reg_we=0.
- Loads: be = 4'b1111 and dm_we = 0. The byte or halfword is selected by the latched addr[1:0]. LB and LH sign-extend; LBU and LHU zero-extend. wb_reg_we = latched ex_reg_we.
- ACCESS: dm_req=1 with dm_we, dm_addr, dm_be and dm_wdata held stable every cycle until the ack or the abort.
  - dm_ack sampled: wb registered from the aligned dm_rdata (loads); go to IDLE.
  - Wait counter reaches MAX_WAIT with no ack: abort. wb_valid=1, wb_reg_we=0, timeout_err=1, go to IDLE.
- waddr 0: wb_reg_we is forced to 0 for every op.
- A dm_ack seen in IDLE is ignored.
- Reset (rstn=0 at an edge): state IDLE, counter 0. dm_req, dm_we, dm_be, wb_valid, wb_reg_we, misalign_err and timeout_err are 0. dm_addr, dm_wdata, wb_reg_waddr and wb_reg_wdata are 0. An access in flight is dropped and no writeback is produced.

## Timing
- All outputs are registered except ex_ready.
- NONE or misaligned accepted at edge N: wb_valid is high for exactly the cycle after N.
- Memory op accepted at edge N: dm_req is high from the cycle after N.
- dm_ack sampled high at edge M:
  - dm_req falls after M.
  - wb_valid is high for the cycle after M.
  - ex_ready is high after M; the next instruction can be accepted at M+1.
- Zero-wait memory (dm_ack high in the first ACCESS cycle): total latency is 2 cycles, acceptance to wb_valid.
- Timeout: the counter is cleared on entry to ACCESS and increments at each edge without an ack. The abort happens at the edge where the count reaches MAX_WAIT; dm_req then falls.
- dm_ack at the abort edge wins over the timeout: the access completes normally.

## Structure
- Package mem_stage_pkg: the ex_mem_op encodings (MEMOP_NONE … MEMOP_SW) and the FSM state encoding. It is shared with the decode stage, which generates ex_mem_op.
- Sub-module mem_load_align: combinational. It takes rdata, addr[1:0] and op, and returns the 32-bit extended load value. The store lane/byte-enable generation stays inline.

## Test plan
- ex_mem_op=NONE, ex_alu_res=0x1234_5678, waddr=3, we=1 → wb_valid one cycle later with wdata=0x1234_5678, we=1, waddr=3; dm_req never asserts.
- SH to 0x0000_1002 with data 0xAAAA_BEEF, ack after 3 cycles → dm_addr=0x1000, be=4'b1100, wdata=0xBEEF_BEEF, held stable; then wb_valid with wb_reg_we=0.
- LB from 0x0000_2003 with rdata=0x80FF_0000 and zero-wait ack → wb_reg_wdata=0xFFFF_FF80. LBU from the same address → 0x0000_0080.
- LW from 0x0000_0006 → misalign_err pulse, dm_req stays 0, wb_valid with we=0, ex_ready never drops.
- LW with no ack and MAX_WAIT=15 → dm_req is high for 15 cycles, then timeout_err and wb_valid with we=0. A late ack in IDLE produces no writeback.
- rstn=0 during ACCESS of an LW to waddr 5 → dm_req is 0 the next cycle, no wb_valid, ex_ready=1 after release.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: memory-op encodings
// (also produced by the decode stage), FSM states and op classification.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LBU  = 4'd2,
    MEMOP_LH   = 4'd3,
    MEMOP_LHU  = 4'd4,
    MEMOP_LW   = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8
  } memOp_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Unused encodings 9..15 behave exactly like NONE.
  function automatic memOp_e decodeOp(input logic [3:0] raw);
    return (raw > 4'd8) ? MEMOP_NONE : memOp_e'(raw);
  endfunction

  function automatic logic isLoad(input memOp_e op);
    return op inside {MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW};
  endfunction

  function automatic logic isStore(input memOp_e op);
    return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW};
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic isAligned(input memOp_e op, input logic [1:0] lane);
    logic ok;
    ok = 1'b1;
    if (op inside {MEMOP_LH, MEMOP_LHU, MEMOP_SH}) ok = ~lane[0];
    if (op inside {MEMOP_LW, MEMOP_SW})            ok = (lane == 2'b00);
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack port. The stage is the master; the memory the slave.
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a read word and extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  memOp_e      op,
  output logic [31:0] loadData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane selection and sign/zero extension of the load value.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    byteSel  = rdata[{addr, 3'b000} +: 8];
    halfSel  = addr[1] ? rdata[31:16] : rdata[15:0];
    loadData = rdata;
    case (op)
      MEMOP_LB:  loadData = {{24{byteSel[7]}}, byteSel};
      MEMOP_LBU: loadData = {24'h0, byteSel};
      MEMOP_LH:  loadData = {{16{halfSel[15]}}, halfSel};
      MEMOP_LHU: loadData = {16'h0, halfSel};
      default:   loadData = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: issues loads/stores over a req/ack port,
// stalls EX while an access is outstanding, and registers WB results.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [3:0]       ex_mem_op,
  input  logic             ex_reg_we,
  input  logic [4:0]       ex_reg_waddr,
  input  logic [31:0]      ex_alu_res,
  input  logic [31:0]      ex_store_data,
  mem_stage_if.master      dmBus,
  output logic             wb_valid,
  output logic             wb_reg_we,
  output logic [4:0]       wb_reg_waddr,
  output logic [31:0]      wb_reg_wdata,
  output logic             misalign_err,
  output logic             timeout_err
);

  localparam logic [7:0] MaxWaitCnt = 8'(MAX_WAIT);

  state_e      state;
  logic [7:0]  waitCnt;
  memOp_e      opQ;
  logic [1:0]  laneQ;
  logic [4:0]  waddrQ;
  logic        weQ;

  memOp_e      exOp;
  logic [1:0]  exLane;
  logic        exWe;
  logic [3:0]  storeBe;
  logic [31:0] storeWdata;
  logic [31:0] loadData;
  logic [7:0]  nextCnt;

  assign ex_ready = (state == IDLE);
  assign exOp     = decodeOp(ex_mem_op);
  assign exLane   = ex_alu_res[1:0];
  // Register 0 is never written, whatever the op.
  assign exWe     = ex_reg_we && (ex_reg_waddr != 5'd0);
  assign nextCnt  = waitCnt + 8'd1;

  // Store byte enables and lane-replicated write data for the incoming op.
  always_comb begin
    storeBe    = 4'b0000;
    storeWdata = ex_store_data;
    case (exOp)
      MEMOP_SB: begin
        storeBe    = 4'b0001 << exLane;
        storeWdata = {4{ex_store_data[7:0]}};
      end
      MEMOP_SH: begin
        storeBe    = exLane[1] ? 4'b1100 : 4'b0011;
        storeWdata = {2{ex_store_data[15:0]}};
      end
      MEMOP_SW: storeBe = 4'b1111;
      default:  storeBe = 4'b0000;
    endcase
  end

  mem_load_align uLoadAlign (
    .rdata    (dmBus.dm_rdata),
    .addr     (laneQ),
    .op       (opQ),
    .loadData (loadData)
  );

  // Stage FSM: accept/issue in IDLE, wait for ack or timeout in ACCESS.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the reset is synchronous, so it only takes effect on a clock edge.
      state          <= IDLE;
      waitCnt        <= 8'd0;
      opQ            <= MEMOP_NONE;
      laneQ          <= 2'b00;
      waddrQ         <= 5'd0;
      weQ            <= 1'b0;
      dmBus.dm_req   <= 1'b0;
      dmBus.dm_we    <= 1'b0;
      dmBus.dm_addr  <= 32'h0;
      dmBus.dm_be    <= 4'h0;
      dmBus.dm_wdata <= 32'h0;
      wb_valid       <= 1'b0;
      wb_reg_we      <= 1'b0;
      wb_reg_waddr   <= 5'd0;
      wb_reg_wdata   <= 32'h0;
      misalign_err   <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (exOp == MEMOP_NONE) begin
              wb_valid     <= 1'b1;
              wb_reg_we    <= exWe;
              wb_reg_waddr <= ex_reg_waddr;
              wb_reg_wdata <= ex_alu_res;
            end else if (!isAligned(exOp, exLane)) begin
              wb_valid     <= 1'b1;
              wb_reg_we    <= 1'b0;
              wb_reg_waddr <= ex_reg_waddr;
              wb_reg_wdata <= ex_alu_res;
              misalign_err <= 1'b1;
            end else begin
              opQ            <= exOp;
              laneQ          <= exLane;
              waddrQ         <= ex_reg_waddr;
              weQ            <= exWe;
              waitCnt        <= 8'd0;
              dmBus.dm_req   <= 1'b1;
              dmBus.dm_we    <= isStore(exOp);
              dmBus.dm_addr  <= {ex_alu_res[31:2], 2'b00};
              dmBus.dm_be    <= isStore(exOp) ? storeBe : 4'b1111;
              dmBus.dm_wdata <= storeWdata;
              state          <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dmBus.dm_ack) begin
            // An ack on the abort edge still completes the access.
            dmBus.dm_req <= 1'b0;
            dmBus.dm_we  <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_we    <= isLoad(opQ) && weQ;
            wb_reg_waddr <= waddrQ;
            wb_reg_wdata <= isLoad(opQ) ? loadData : 32'h0;
            state        <= IDLE;
          end else if (nextCnt == MaxWaitCnt) begin
            dmBus.dm_req <= 1'b0;
            dmBus.dm_we  <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_we    <= 1'b0;
            wb_reg_waddr <= waddrQ;
            wb_reg_wdata <= 32'h0;
            timeout_err  <= 1'b1;
            waitCnt      <= nextCnt;
            state        <= IDLE;
          end else begin
            waitCnt <= nextCnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected writebacks popped
// by a monitor on wb_valid, plus direct checks of the memory port.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned MaxWait = 15;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ex_valid, ex_ready, ex_reg_we;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_reg_waddr;
  logic [31:0] ex_alu_res, ex_store_data;
  logic        wb_valid, wb_reg_we, misalign_err, timeout_err;
  logic [4:0]  wb_reg_waddr;
  logic [31:0] wb_reg_wdata;

  mem_stage_if dmIf ();

  mem_stage #(.MAX_WAIT(MaxWait)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_mem_op     (ex_mem_op),
    .ex_reg_we     (ex_reg_we),
    .ex_reg_waddr  (ex_reg_waddr),
    .ex_alu_res    (ex_alu_res),
    .ex_store_data (ex_store_data),
    .dmBus         (dmIf),
    .wb_valid      (wb_valid),
    .wb_reg_we     (wb_reg_we),
    .wb_reg_waddr  (wb_reg_waddr),
    .wb_reg_wdata  (wb_reg_wdata),
    .misalign_err  (misalign_err),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          chkData;
    logic        mis;
    logic        tmo;
  } wbExp_t;

  wbExp_t sb[$];
  int     checks = 0;
  int     errors = 0;
  bit     monEn = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expectWb(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                          input bit chkData, input logic mis, input logic tmo);
    wbExp_t e;
    e.we = we; e.waddr = waddr; e.wdata = wdata;
    e.chkData = chkData; e.mis = mis; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one instruction for a single edge; call at a negedge with ex_ready high.
  task automatic issue(input logic [3:0] op, input logic we, input logic [4:0] waddr,
                       input logic [31:0] alu, input logic [31:0] sdata);
    ex_valid = 1'b1; ex_mem_op = op; ex_reg_we = we; ex_reg_waddr = waddr;
    ex_alu_res = alu; ex_store_data = sdata;
    step();
    ex_valid = 1'b0; ex_mem_op = 4'd0; ex_reg_we = 1'b0;
  endtask

  // Issues a memory op, holds ack low for `waits` ACCESS cycles checking the
  // port is stable, then acks with rdata.
  task automatic access(input string tag, input logic [3:0] op, input logic we,
                        input logic [4:0] waddr, input logic [31:0] alu,
                        input logic [31:0] sdata, input logic [31:0] rdata, input int waits,
                        input logic expWe, input logic [3:0] expBe,
                        input logic [31:0] expWdata, input bit chkW);
    issue(op, we, waddr, alu, sdata);
    for (int i = 0; i <= waits; i++) begin
      check({tag, "_req"}, dmIf.dm_req, 32'd1);
      check({tag, "_addr"}, dmIf.dm_addr, alu & 32'hFFFF_FFFC);
      check({tag, "_be"}, dmIf.dm_be, expBe);
      check({tag, "_we"}, dmIf.dm_we, expWe);
      if (chkW) check({tag, "_wdata"}, dmIf.dm_wdata, expWdata);
      check({tag, "_stall"}, ex_ready, 32'd0);
      if (i == waits) begin
        dmIf.dm_ack = 1'b1;
        dmIf.dm_rdata = rdata;
      end
      step();
    end
    dmIf.dm_ack = 1'b0;
    dmIf.dm_rdata = 32'h0;
    check({tag, "_req_fall"}, dmIf.dm_req, 32'd0);
    check({tag, "_wb_valid"}, wb_valid, 32'd1);
    check({tag, "_ready"}, ex_ready, 32'd1);
  endtask

  // Scoreboard monitor: every wb_valid must match the oldest expectation.
  always @(negedge clk) begin
    wbExp_t e;
    if (monEn) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", {31'b0, wb_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("wb_reg_we", wb_reg_we, e.we);
          check("wb_reg_waddr", wb_reg_waddr, e.waddr);
          if (e.chkData) check("wb_reg_wdata", wb_reg_wdata, e.wdata);
          check("misalign_err", misalign_err, e.mis);
          check("timeout_err", timeout_err, e.tmo);
        end
      end else begin
        check("stray_err", {30'b0, misalign_err, timeout_err}, 32'd0);
      end
    end
  end

  initial begin
    int reqCycles;
    ex_valid = 1'b0; ex_mem_op = 4'd0; ex_reg_we = 1'b0; ex_reg_waddr = 5'd0;
    ex_alu_res = 32'h0; ex_store_data = 32'h0;
    dmIf.dm_ack = 1'b0; dmIf.dm_rdata = 32'h0;

    // Reset state
    rstn = 1'b0;
    step(); step();
    check("rst_dm_req", dmIf.dm_req, 32'd0);
    check("rst_dm_we", dmIf.dm_we, 32'd0);
    check("rst_dm_be", dmIf.dm_be, 32'd0);
    check("rst_dm_addr", dmIf.dm_addr, 32'd0);
    check("rst_dm_wdata", dmIf.dm_wdata, 32'd0);
    check("rst_wb_valid", wb_valid, 32'd0);
    check("rst_wb_we", wb_reg_we, 32'd0);
    check("rst_wb_waddr", wb_reg_waddr, 32'd0);
    check("rst_wb_wdata", wb_reg_wdata, 32'd0);
    check("rst_errs", {misalign_err, timeout_err}, 32'd0);
    check("rst_ready", ex_ready, 32'd1);
    rstn = 1'b1;
    monEn = 1'b1;
    step();

    // NONE: registered passthrough, one-cycle strobe, no memory request
    expectWb(1'b1, 5'd3, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    issue(4'd0, 1'b1, 5'd3, 32'h1234_5678, 32'h0);
    check("none_wb_valid", wb_valid, 32'd1);
    check("none_no_req", dmIf.dm_req, 32'd0);
    step();
    check("none_pulse", wb_valid, 32'd0);
    check("none_no_req2", dmIf.dm_req, 32'd0);

    // Encoding 12 behaves as NONE; waddr 0 forces we low
    expectWb(1'b0, 5'd0, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
    issue(4'd12, 1'b1, 5'd0, 32'hCAFE_0001, 32'h0);
    check("op12_no_req", dmIf.dm_req, 32'd0);
    step();

    // Stores
    expectWb(1'b0, 5'd7, 32'h0, 1'b0, 1'b0, 1'b0);
    access("sh", 4'd7, 1'b1, 5'd7, 32'h0000_1002, 32'hAAAA_BEEF, 32'h5555_5555, 3,
           1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b1);
    step();
    expectWb(1'b0, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0);
    access("sb", 4'd6, 1'b1, 5'd2, 32'h0000_0041, 32'h1234_56A5, 32'h0, 0,
           1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b1);
    step();
    expectWb(1'b0, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0);
    access("sw", 4'd8, 1'b1, 5'd2, 32'h0000_0080, 32'h0102_0304, 32'h0, 1,
           1'b1, 4'b1111, 32'h0102_0304, 1'b1);
    step();

    // Loads with sign/zero extension
    expectWb(1'b1, 5'd4, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
    access("lb", 4'd1, 1'b1, 5'd4, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0,
           1'b0, 4'b1111, 32'h0, 1'b0);
    expectWb(1'b1, 5'd4, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
    access("lbu", 4'd2, 1'b1, 5'd4, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0,
           1'b0, 4'b1111, 32'h0, 1'b0);
    expectWb(1'b1, 5'd8, 32'hFFFF_80FF, 1'b1, 1'b0, 1'b0);
    access("lh", 4'd3, 1'b1, 5'd8, 32'h0000_2002, 32'h0, 32'h80FF_0000, 2,
           1'b0, 4'b1111, 32'h0, 1'b0);
    expectWb(1'b1, 5'd9, 32'h0000_F00D, 1'b1, 1'b0, 1'b0);
    access("lhu", 4'd4, 1'b1, 5'd9, 32'h0000_2000, 32'h0, 32'h1234_F00D, 0,
           1'b0, 4'b1111, 32'h0, 1'b0);
    expectWb(1'b0, 5'd0, 32'h0000_F00D, 1'b1, 1'b0, 1'b0);
    access("lhu_r0", 4'd4, 1'b1, 5'd0, 32'h0000_2000, 32'h0, 32'h1234_F00D, 0,
           1'b0, 4'b1111, 32'h0, 1'b0);
    // Ack on the abort edge wins over the timeout
    expectWb(1'b1, 5'd10, 32'h89AB_CDEF, 1'b1, 1'b0, 1'b0);
    access("lw_edge", 4'd5, 1'b1, 5'd10, 32'h0000_0300, 32'h0, 32'h89AB_CDEF,
           int'(MaxWait) - 1, 1'b0, 4'b1111, 32'h0, 1'b0);
    step();

    // Misaligned accesses: no request, error pulse, no stall
    expectWb(1'b0, 5'd9, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(4'd5, 1'b1, 5'd9, 32'h0000_0006, 32'h0);
    check("mis_lw_req", dmIf.dm_req, 32'd0);
    check("mis_lw_ready", ex_ready, 32'd1);
    check("mis_lw_wb", wb_valid, 32'd1);
    step();
    check("mis_lw_req2", dmIf.dm_req, 32'd0);
    check("mis_lw_ready2", ex_ready, 32'd1);
    expectWb(1'b0, 5'd2, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(4'd7, 1'b1, 5'd2, 32'h0000_1003, 32'h0);
    check("mis_sh_req", dmIf.dm_req, 32'd0);
    expectWb(1'b0, 5'd11, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(4'd3, 1'b1, 5'd11, 32'h0000_2001, 32'h0);
    check("mis_lh_req", dmIf.dm_req, 32'd0);
    step();

    // Timeout: request held MAX_WAIT cycles, then abort
    expectWb(1'b0, 5'd6, 32'h0, 1'b0, 1'b0, 1'b1);
    issue(4'd5, 1'b1, 5'd6, 32'h0000_0100, 32'h0);
    reqCycles = 0;
    for (int i = 0; i < 40 && dmIf.dm_req === 1'b1; i++) begin
      reqCycles++;
      step();
    end
    check("tmo_req_cycles", reqCycles, MaxWait);
    check("tmo_err", timeout_err, 32'd1);
    check("tmo_wb_valid", wb_valid, 32'd1);
    check("tmo_ready", ex_ready, 32'd1);
    // A late ack in IDLE is ignored
    dmIf.dm_ack = 1'b1;
    dmIf.dm_rdata = 32'h0000_0077;
    step(); step();
    check("late_ack_no_wb", wb_valid, 32'd0);
    check("late_ack_no_req", dmIf.dm_req, 32'd0);
    dmIf.dm_ack = 1'b0;
    step();

    // Reset in ACCESS drops the access
    issue(4'd5, 1'b1, 5'd5, 32'h0000_0200, 32'h0);
    check("rst_acc_req", dmIf.dm_req, 32'd1);
    rstn = 1'b0;
    step();
    check("rst_acc_req_drop", dmIf.dm_req, 32'd0);
    check("rst_acc_no_wb", wb_valid, 32'd0);
    rstn = 1'b1;
    step();
    check("rst_acc_ready", ex_ready, 32'd1);
    check("rst_acc_no_wb2", wb_valid, 32'd0);

    // Stage works again after the in-flight reset
    expectWb(1'b1, 5'd5, 32'hA5A5_0000, 1'b1, 1'b0, 1'b0);
    issue(4'd0, 1'b1, 5'd5, 32'hA5A5_0000, 32'h0);
    step(); step();
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
